// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 absorb buffer.
// Holds the default geometry, the bank-state encoding and the error bit positions.
package sha3_pkg;

  localparam int CHUNK_W_DEF = 200;
  localparam int NCHUNK_DEF  = 8;
  localparam int IDX_W_DEF   = 3;
  localparam int STATE_W     = CHUNK_W_DEF * NCHUNK_DEF;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_BAD_IDX = 1;

endpackage

// File: rtl/sha3_absorb_bank.sv
// One bank of the absorb buffer: state image, per-chunk write mask and fill state.
//
//   state        | meaning
//   BANK_EMPTY   | nothing written since last release or reset
//   BANK_FILLING | at least one chunk written, block not yet closed
//   BANK_FULL    | block closed, held for the permutation core
module sha3_absorb_bank
  import sha3_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK  = NCHUNK_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCHUNK-1:0]         wr_sel,
  input  logic [CHUNK_W-1:0]        wr_data,
  input  logic                      set_full,
  input  logic                      clear,
  output logic [CHUNK_W*NCHUNK-1:0] data,
  output logic [NCHUNK-1:0]         mask,
  output bank_state_e               state
);

  bank_state_e state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BANK_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)         state_next = BANK_EMPTY;
    else if (set_full) state_next = BANK_FULL;
    else if (|wr_sel)  state_next = BANK_FILLING;
  end

  // Unwritten chunks stay zero, which is what short rate blocks rely on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      mask <= '0;
    end else if (clear) begin
      data <= '0;
      mask <= '0;
    end else begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (wr_sel[k]) begin
          data[k*CHUNK_W +: CHUNK_W] <= wr_data;
          mask[k]                    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sha3_absorb_buffer.sv
// Double-buffered SHA-3 input stage: one bank fills from indexed chunks while the
// other presents a completed block to the permutation core.
module sha3_absorb_buffer
  import sha3_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNK  = NCHUNK_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pushin,
  input  logic [IDX_W-1:0]          dix,
  input  logic [CHUNK_W-1:0]        din,
  input  logic                      lastin,
  output logic                      inready,
  output logic [CHUNK_W*NCHUNK-1:0] dout,
  output logic [NCHUNK-1:0]         dmask,
  output logic                      doutv,
  input  logic                      doutack,
  output logic [1:0]                err
);

  localparam int IMG_W = CHUNK_W * NCHUNK;

  logic              wrbank;
  logic              rdbank;
  logic [IMG_W-1:0]  bank_data [2];
  logic [NCHUNK-1:0] bank_mask [2];
  bank_state_e       bank_state [2];

  logic [NCHUNK-1:0] idx_hit;
  logic [NCHUNK-1:0] wr_sel;
  logic [NCHUNK-1:0] mask_upd;
  logic              idx_ok;
  logic              dup;
  logic              accept;
  logic              complete;
  logic              release_blk;

  // Out-of-range indices simply match no chunk, so they never write.
  always_comb begin
    idx_hit = '0;
    for (int k = 0; k < NCHUNK; k++) idx_hit[k] = (dix == IDX_W'(k));
  end

  assign idx_ok      = |idx_hit;
  assign dup         = |(idx_hit & bank_mask[wrbank]);
  assign inready     = (bank_state[wrbank] != BANK_FULL);
  assign accept      = pushin & inready;
  assign wr_sel      = (accept && !dup) ? idx_hit : '0;
  assign mask_upd    = bank_mask[wrbank] | wr_sel;
  assign complete    = accept & (lastin | (&mask_upd));
  assign doutv       = (bank_state[rdbank] == BANK_FULL);
  assign release_blk = doutv & doutack;
  assign dout        = doutv ? bank_data[rdbank] : '0;
  assign dmask       = doutv ? bank_mask[rdbank] : '0;

  // A released bank is always FULL while the accepting bank never is, so the
  // clear and set_full strobes can never target the same bank in one cycle.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_wr;
    logic is_rd;
    assign is_wr = (wrbank == 1'(b));
    assign is_rd = (rdbank == 1'(b));

    sha3_absorb_bank #(
      .CHUNK_W (CHUNK_W),
      .NCHUNK  (NCHUNK)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_sel   (is_wr ? wr_sel : '0),
      .wr_data  (din),
      .set_full (complete & is_wr),
      .clear    (release_blk & is_rd),
      .data     (bank_data[b]),
      .mask     (bank_mask[b]),
      .state    (bank_state[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrbank <= 1'b0;
      rdbank <= 1'b0;
      err    <= '0;
    end else begin
      if (complete)    wrbank <= ~wrbank;
      if (release_blk) rdbank <= ~rdbank;
      if (pushin && !inready)         err[ERR_OVERRUN] <= 1'b1;
      if (accept && (!idx_ok || dup)) err[ERR_BAD_IDX] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// Scoreboard bench for sha3_absorb_buffer: a block-level model queues expected
// blocks, and a negedge monitor compares every presented block against the queue.
module tb_sha3_absorb_buffer;
  import sha3_pkg::*;

  localparam int CW = CHUNK_W_DEF;
  localparam int NC = NCHUNK_DEF;
  localparam int IW = IDX_W_DEF;

  typedef logic [CW-1:0]      chunk_t;
  typedef logic [STATE_W-1:0] img_t;
  typedef struct {
    img_t            img;
    logic [NC-1:0]   mask;
  } blk_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pushin = 1'b0;
  logic [IW-1:0] dix = '0;
  chunk_t        din = '0;
  logic          lastin = 1'b0;
  logic          inready;
  img_t          dout;
  logic [NC-1:0] dmask;
  logic          doutv;
  logic          doutack = 1'b0;
  logic [1:0]    err;

  sha3_absorb_buffer #(.CHUNK_W(CW), .NCHUNK(NC), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .pushin  (pushin),
    .dix     (dix),
    .din     (din),
    .lastin  (lastin),
    .inready (inready),
    .dout    (dout),
    .dmask   (dmask),
    .doutv   (doutv),
    .doutack (doutack),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the block being assembled, completed blocks awaiting the core.
  blk_t          exp_q[$];
  chunk_t        cur_chunk [NC];
  logic [NC-1:0] cur_mask;
  int            pending;
  logic [1:0]    err_exp;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void chk_img(input string name, input img_t act, input img_t req);
    total++;
    if (act !== req) begin
      bad++;
      for (int k = 0; k < NC; k++) begin
        if (act[k*CW +: CW] !== req[k*CW +: CW]) begin
          $display("FAIL %s chunk=%0d actual=%h required=%h", name, k,
                   act[k*CW +: CW], req[k*CW +: CW]);
          break;
        end
      end
    end
  endfunction

  function automatic chunk_t rnd_chunk();
    chunk_t r;
    for (int i = 0; i < CW / 8; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NC; k++) cur_chunk[k] = '0;
    cur_mask = '0;
  endfunction

  // Monitor: whenever a block is presented it must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (doutv === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_block actual=doutv required=no_block");
        end else begin
          chk_img("dout", dout, exp_q[0].img);
          chk("dmask", 64'(dmask), 64'(exp_q[0].mask));
          if (doutack === 1'b1) exp_q.delete(0);
        end
      end else begin
        chk_img("dout_idle", dout, '0);
        chk("dmask_idle", 64'(dmask), 64'd0);
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic step(input bit p, input int ix, input chunk_t d, input bit l, input bit a);
    bit   acc;
    bit   done;
    bit   rel;
    blk_t b;
    chk("inready", 64'(inready), 64'(pending < 2));
    chk("doutv", 64'(doutv), 64'(pending > 0));
    chk("err", 64'(err), 64'(err_exp));
    pushin  = p;
    dix     = IW'(ix);
    din     = d;
    lastin  = l;
    doutack = a;
    acc  = p && (pending < 2);
    rel  = a && (pending > 0);
    done = 1'b0;
    if (p && !acc) err_exp[ERR_OVERRUN] = 1'b1;
    if (acc) begin
      if (ix < NC && !cur_mask[ix]) begin
        cur_chunk[ix] = d;
        cur_mask[ix]  = 1'b1;
      end else begin
        err_exp[ERR_BAD_IDX] = 1'b1;
      end
      if (l || (&cur_mask)) begin
        for (int k = 0; k < NC; k++) b.img[k*CW +: CW] = cur_chunk[k];
        b.mask = cur_mask;
        exp_q.push_back(b);
        model_clear();
        done = 1'b1;
      end
    end
    pending = pending + int'(done) - int'(rel);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit a);
    step(1'b0, 0, '0, 1'b0, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && pending > 0; i++) idle(1'b1);
    idle(1'b0);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    pushin  = 1'b0;
    lastin  = 1'b0;
    doutack = 1'b0;
    reset   = 1'b0;
    #1;
    chk("rst_inready", 64'(inready), 64'd1);
    chk("rst_doutv", 64'(doutv), 64'd0);
    chk("rst_dmask", 64'(dmask), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_img("rst_dout", dout, '0);
    model_clear();
    exp_q.delete();
    pending = 0;
    err_exp = '0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    pending = 0;
    err_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Full block with lastin on the final chunk, held until acked.
    for (int k = 0; k < NC; k++) step(1'b1, k, chunk_t'(k + 1), k == NC - 1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Short block, ack held high.
    for (int k = 0; k < 5; k++) step(1'b1, k, rnd_chunk(), k == 4, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Both banks full, overrun push dropped, then one ack reopens input.
    for (int k = 0; k < 2 * NC; k++) step(1'b1, k % NC, rnd_chunk(), 1'b0, 1'b0);
    step(1'b1, 3, rnd_chunk(), 1'b1, 1'b0);
    idle(1'b0);
    step(1'b1, 0, rnd_chunk(), 1'b0, 1'b1);
    step(1'b1, 0, rnd_chunk(), 1'b1, 1'b0);
    drain();

    // Duplicate index keeps the first value and still completes on all-ones.
    do_reset();
    step(1'b1, 2, rnd_chunk(), 1'b0, 1'b0);
    step(1'b1, 2, rnd_chunk(), 1'b0, 1'b0);
    for (int k = 0; k < NC; k++) if (k != 2) step(1'b1, k, rnd_chunk(), 1'b0, 1'b0);
    step(1'b1, 5, rnd_chunk(), 1'b0, 1'b0);
    step(1'b1, 5, rnd_chunk(), 1'b1, 1'b0);
    drain();

    // Continuous 16-chunk stream with ack held high.
    do_reset();
    for (int k = 0; k < 2 * NC; k++) step(1'b1, (k * 3) % NC, rnd_chunk(), 1'b0, 1'b1);
    drain();

    // Reset in the middle of a block discards it.
    for (int k = 0; k < 3; k++) step(1'b1, k, rnd_chunk(), 1'b0, 1'b0);
    do_reset();
    for (int k = 0; k < NC; k++) step(1'b1, NC - 1 - k, rnd_chunk(), 1'b0, 1'b0);
    drain();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, NC - 1)), rnd_chunk(),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha3_absorb_buffer.md
# sha3_absorb_buffer

Parametrised, double-buffered input stage for the SHA-3 permutation core. Collects fixed-width message chunks addressed by index into a full Keccak state image, then presents a completed block to the core with a valid/ack handshake. One bank fills while the other is held for the core, so input streaming continues during a permutation. Supports full and short (rate-limited) blocks via an end-of-block marker.

## Interface
- CHUNK_W, 200, width of one input chunk in bits
- NCHUNK, 8, chunks per state image; image width is CHUNK_W*NCHUNK (1600 default)
- IDX_W, 3, width of chunk index; must satisfy 2**IDX_W >= NCHUNK

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pushin  in  1  chunk strobe
- dix  in  IDX_W  chunk index; chunk k lands at dout[k*CHUNK_W +: CHUNK_W]
- din  in  CHUNK_W  chunk data
- lastin  in  1  qualifies pushin; this chunk ends the block
- inready  out  1  a push is accepted this cycle
- dout  out  CHUNK_W*NCHUNK  state image of the read bank
- dmask  out  NCHUNK  chunks written in the read bank
- doutv  out  1  read bank holds a completed block
- doutack  in  1  consumer takes the block
- err  out  2  sticky: [0] push while inready=0, [1] bad index (out of range or duplicate)

## Operation
- Two banks, each with state EMPTY / FILLING / FULL, a data register and a write mask. Pointers wrbank, rdbank (1 bit each).
- Reset (reset=0, asynchronous): both banks EMPTY, data and masks zero, wrbank=rdbank=0, err=0. Outputs: inready=1, doutv=0, dout=0, dmask=0.
- inready = (bank[wrbank] != FULL).
- Accepted push (pushin & inready): if dix < NCHUNK and mask bit clear, write din to chunk dix, set mask bit, bank -> FILLING. If dix >= NCHUNK or mask bit already set: data discarded, err[1] set, completion logic still evaluated.
- Block completion on an accepted push when lastin=1 or the updated mask is all ones: bank[wrbank] -> FULL, wrbank toggles.
- Unwritten chunks of a completed block read as zero (short rate blocks).
- Push with inready=0: dropped, no state change, err[0] set.
- doutv = (bank[rdbank] == FULL); dout/dmask driven from bank[rdbank], zero when not FULL.
- doutv & doutack: bank[rdbank] -> EMPTY, data and mask cleared, rdbank toggles. doutack with doutv=0 ignored.
- err bits clear only on reset.

## Timing
- Completing push at edge N -> doutv=1 in the cycle after edge N (one-cycle latency) if that bank is rdbank.
- Release and completion in the same cycle both take effect: the released bank is EMPTY and the completed bank is FULL after the edge.
- Release at edge N makes inready=1 after edge N when both banks were FULL; a push in cycle N itself is still dropped.
- Back-to-back blocks: sustained one chunk per cycle with doutack held high; no bubbles.
- dout stable while doutv=1 and doutack=0.
- Asserting reset mid-block discards both banks immediately; no partial block is presented.

## Structure
- Shared package sha3_pkg: default CHUNK_W, NCHUNK, STATE_W (1600), bank-state enum (EMPTY, FILLING, FULL), err bit positions.
- One sub-module natural: sha3_absorb_bank (data register, mask, state, write/clear ports), instantiated twice; top holds pointers, handshake, err.

## Test plan
- Reset then push dix 0..7 with din=k+1, lastin on dix 7 -> doutv high next cycle, chunk k = k+1, dmask=8'hFF, inready stays 1.
- Push dix 0..4 with lastin on dix 4, doutack=1 -> dmask=8'h1F, chunks 5..7 zero; after ack dout=0, doutv=0.
- Fill two blocks with doutack=0 -> inready=0 after second completion; third push dropped, err=2'b01; one ack -> inready=1, first block data unchanged until ack.
- Push dix 2 twice with different data -> first value retained, err[1]=1, block still completes on all-ones mask or lastin.
- Continuous 16-chunk stream with doutack=1 and ack coinciding with final push -> two blocks presented in order, no drops, err=0.
- Assert reset mid-fill after 3 chunks -> doutv=0, dmask=0, dout=0, inready=1 immediately; next full block presents only new data.
